// File: rtl/counter_event_capture_pkg.sv
// Shared definitions for the counter event capture block.
//   evt_type_e  : record type code (01 match, 10 wrap, 11 both)
//   CNT_W_DEF   : default width of the monitored counter value
//   evt_encode  : builds the type code from the two event strobes
package counter_event_capture_pkg;

   localparam int CNT_W_DEF = 6;

   typedef enum logic [1:0] {
      EVT_NONE  = 2'b00,
      EVT_MATCH = 2'b01,
      EVT_WRAP  = 2'b10,
      EVT_BOTH  = 2'b11
   } evt_type_e;

   function automatic evt_type_e evt_encode(input logic match, input logic wrap);
      return evt_type_e'({wrap, match});
   endfunction

endpackage

// File: rtl/counter_event_capture_sync_fifo.sv
// sync_fifo: pointer-based FIFO with a registered head word.
//   clk, rst (async active-low)
//   wr_en/wr_data : write request; accepted when not full, or when full and
//                   a pop happens in the same cycle
//   rd_en         : pop request, honoured only when not empty
//   rd_data       : head record; holds the last popped value while empty
//   full, empty, level : occupancy status (level 0..DEPTH)
module sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   import counter_event_capture_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW-1:0]    rd_ptr_inc;
   logic [AW:0]      count_reg;
   logic [WIDTH-1:0] head_reg;
   logic             push;
   logic             pop;

   assign empty      = (count_reg == '0);
   assign full       = (count_reg == (AW+1)'(DEPTH));
   assign pop        = rd_en & ~empty;
   // A full FIFO can still take a write when the head leaves in the same cycle.
   assign push       = wr_en & (~full | pop);
   assign rd_ptr_inc = rd_ptr_reg + AW'(1);
   assign rd_data    = head_reg;
   assign level      = count_reg;

   // Storage array without reset so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_inc;
         end
         count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
         // Head register: the incoming word becomes head when the FIFO is
         // (or is about to be) otherwise empty; else the next stored word is
         // read on a pop. With no successor the popped value is held.
         if (push && (empty || (pop && count_reg == (AW+1)'(1)))) begin
            head_reg <= wr_data;
         end else if (pop && count_reg > (AW+1)'(1)) begin
            head_reg <= mem[rd_ptr_inc];
         end
      end
   end

endmodule

// File: rtl/counter_event_capture.sv
// counter_event_capture: watches a counter value, detects threshold entry and
// terminal-count wrap, and queues timestamped records for a host to drain.
//   clk, rst (async active-low)
//   cnt_in, thr, arm          : monitored value, match threshold, detect enable
//   out_valid/out_ready       : head record handshake
//   out_type/out_cnt/out_stamp: head record fields
//   level                     : FIFO occupancy
//   ovf, ovf_clr              : sticky drop flag and its clear
module counter_event_capture
   import counter_event_capture_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DEPTH   = 4,
   parameter int STAMP_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CNT_W-1:0]         cnt_in,
   input  logic [CNT_W-1:0]         thr,
   input  logic                     arm,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               out_type,
   output logic [CNT_W-1:0]         out_cnt,
   output logic [STAMP_W-1:0]       out_stamp,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf,
   input  logic                     ovf_clr
);

   localparam int REC_W = 2 + CNT_W + STAMP_W;

   logic [STAMP_W-1:0] stamp_reg;
   logic [CNT_W-1:0]   cnt_q_reg;
   logic               prev_ok_reg;
   logic               ovf_reg;
   logic               match_evt;
   logic               wrap_evt;
   logic               evt;
   evt_type_e          evt_type;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic [REC_W-1:0]   wr_data;
   logic [REC_W-1:0]   rd_data;

   // Match fires only on entry to thr, so a counter parked at thr (or a thr
   // that already equals the held value when arm rises) yields no event.
   assign match_evt = arm & prev_ok_reg & (cnt_in == thr) & (cnt_q_reg != thr);
   assign wrap_evt  = arm & prev_ok_reg & (cnt_q_reg == {CNT_W{1'b1}}) & (cnt_in == '0);
   assign evt       = match_evt | wrap_evt;
   assign evt_type  = evt_encode(match_evt, wrap_evt);
   assign wr_data   = {evt_type, cnt_in, stamp_reg};

   // out_valid comes straight from the registered occupancy, so out_ready has
   // no combinational path to it.
   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;

   assign out_type  = rd_data[REC_W-1 -: 2];
   assign out_cnt   = rd_data[STAMP_W +: CNT_W];
   assign out_stamp = rd_data[STAMP_W-1:0];
   assign ovf       = ovf_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stamp_reg   <= '0;
         cnt_q_reg   <= '0;
         prev_ok_reg <= 1'b0;
         ovf_reg     <= 1'b0;
      end else begin
         stamp_reg   <= stamp_reg + STAMP_W'(1);
         cnt_q_reg   <= cnt_in;
         prev_ok_reg <= 1'b1;
         // A drop in the same cycle as a clear leaves the flag set.
         if (evt && fifo_full && !pop) begin
            ovf_reg <= 1'b1;
         end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
         end
      end
   end

   sync_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (evt),
      .wr_data (wr_data),
      .rd_en   (out_ready),
      .rd_data (rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

endmodule

// File: tb/tb_counter_event_capture.sv
module tb_counter_event_capture;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [5:0]  cnt_in;
   logic [5:0]  thr;
   logic        arm;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_type;
   logic [5:0]  out_cnt;
   logic [15:0] out_stamp;
   logic [2:0]  level;
   logic        ovf;
   logic        ovf_clr;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [1:0]  t;
      logic [5:0]  c;
      logic [15:0] s;
   } rec_t;

   // Reference model state: records queued, sticky drop flag, cycle counter,
   // previous counter value and whether a previous value exists yet.
   rec_t        q[$];
   rec_t        last_head;
   logic        ovf_m;
   logic [15:0] stamp_m;
   logic [5:0]  prev_cnt_m;
   logic        prev_ok_m;

   counter_event_capture #(.CNT_W(6), .DEPTH(DEPTH), .STAMP_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .cnt_in    (cnt_in),
      .thr       (thr),
      .arm       (arm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_type  (out_type),
      .out_cnt   (out_cnt),
      .out_stamp (out_stamp),
      .level     (level),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      q.delete();
      last_head  = '{2'b00, 6'd0, 16'd0};
      ovf_m      = 1'b0;
      stamp_m    = 16'd0;
      prev_cnt_m = 6'd0;
      prev_ok_m  = 1'b0;
   endtask

   // Advance one clock: the model applies the event/pop/drop rules to the
   // inputs present during this cycle, then DUT outputs are sampled 1ns after
   // the edge.
   task automatic tick();
      int   sz;
      bit   m, w, p, drop;
      rec_t r;
      sz   = q.size();
      m    = arm && prev_ok_m && (cnt_in == thr) && (prev_cnt_m != thr);
      w    = arm && prev_ok_m && (prev_cnt_m == 6'd63) && (cnt_in == 6'd0);
      p    = (sz > 0) && out_ready;
      drop = 0;
      if (p) void'(q.pop_front());
      if (m || w) begin
         r.t = {w, m};
         r.c = cnt_in;
         r.s = stamp_m;
         if (sz < DEPTH || p) q.push_back(r);
         else drop = 1;
      end
      if (drop) ovf_m = 1'b1;
      else if (ovf_clr) ovf_m = 1'b0;
      stamp_m    = stamp_m + 16'd1;
      prev_cnt_m = cnt_in;
      prev_ok_m  = 1'b1;
      @(posedge clk);
      #1;
      if (q.size() > 0) last_head = q[0];
   endtask

   task automatic test_reset();
      rst = 1'b0; cnt_in = 6'd0; thr = 6'd0; arm = 1'b1;
      out_ready = 1'b0; ovf_clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
      checks++; if (out_type !== 2'b00 || out_cnt !== 6'd0 || out_stamp !== 16'd0) begin
         errors++; $display("FAIL reset_head: got type=%0b cnt=%0d stamp=%0d expected all 0", out_type, out_cnt, out_stamp);
      end
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin
         errors++; $display("FAIL idle_after_reset: got valid=%0b level=%0d expected 0/0", out_valid, level);
      end
      $display("test_reset: valid=%0b level=%0d ovf=%0b", out_valid, level, ovf);
   endtask

   task automatic test_match();
      int nvalid = 0;
      thr = 6'd5; out_ready = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         cnt_in = 6'(i);
         tick();
         checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL match_valid i=%0d: got %0b expected %0b", i, out_valid, q.size() != 0); end
         if (out_valid === 1'b1) begin
            nvalid++;
            checks++; if (i != 5) begin errors++; $display("FAIL match_latency: valid after cnt_in=%0d expected after 5", i); end
            checks++; if (out_type !== 2'b01 || out_cnt !== 6'd5) begin errors++; $display("FAIL match_rec: got type=%0b cnt=%0d expected 01/5", out_type, out_cnt); end
            checks++; if (out_stamp !== last_head.s) begin errors++; $display("FAIL match_stamp: got %0d expected %0d", out_stamp, last_head.s); end
         end
      end
      checks++; if (nvalid != 1) begin errors++; $display("FAIL match_count: got %0d expected 1", nvalid); end
      $display("test_match: records seen=%0d", nvalid);
   endtask

   task automatic test_wrap_both();
      int         seq [4]  = '{62, 63, 0, 1};
      logic [5:0] th  [2]  = '{6'd0, 6'd9};
      logic [1:0] et  [2]  = '{2'b11, 2'b10};
      out_ready = 1'b1;
      for (int p = 0; p < 2; p++) begin
         thr = th[p];
         for (int k = 0; k < 4; k++) begin
            cnt_in = 6'(seq[k]);
            tick();
            checks++; if (out_valid !== (k == 2)) begin errors++; $display("FAIL wrap_valid thr=%0d k=%0d: got %0b expected %0b", thr, k, out_valid, k == 2); end
            if (k == 2) begin
               checks++; if (out_type !== et[p] || out_cnt !== 6'd0) begin
                  errors++; $display("FAIL wrap_rec thr=%0d: got type=%0b cnt=%0d expected %0b/0", thr, out_type, out_cnt, et[p]);
               end
            end
         end
         $display("test_wrap_both: thr=%0d type expected=%0b", thr, et[p]);
      end
   endtask

   task automatic test_overflow();
      out_ready = 1'b0; thr = 6'd9;
      for (int i = 0; i < 5; i++) begin
         cnt_in = 6'd63; tick();
         cnt_in = 6'd0;  tick();
      end
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", level); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", ovf); end
      checks++; if (out_stamp !== last_head.s || out_type !== 2'b10) begin
         errors++; $display("FAIL ovf_head: got stamp=%0d type=%0b expected %0d/10", out_stamp, out_type, last_head.s);
      end
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b expected 0", ovf); end
      $display("test_overflow: level=%0d ovf after clear=%0b", level, ovf);
   endtask

   task automatic test_full_pop();
      cnt_in = 6'd63; out_ready = 1'b0; tick();
      cnt_in = 6'd0;  out_ready = 1'b1; tick();
      out_ready = 1'b0;
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullpop_level: got %0d expected 4", level); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %0b expected 0", ovf); end
      checks++; if (out_stamp !== last_head.s) begin errors++; $display("FAIL fullpop_head: got %0d expected %0d", out_stamp, last_head.s); end
      $display("test_full_pop: level=%0d ovf=%0b", level, ovf);
   endtask

   task automatic test_drain();
      logic [15:0] prev = 16'd0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid i=%0d: got %0b expected 1", i, out_valid); end
         checks++; if (out_stamp !== q[0].s) begin errors++; $display("FAIL drain_stamp i=%0d: got %0d expected %0d", i, out_stamp, q[0].s); end
         if (i > 0) begin
            checks++; if (out_stamp <= prev) begin errors++; $display("FAIL drain_order i=%0d: got %0d expected above %0d", i, out_stamp, prev); end
         end
         prev = out_stamp;
         $display("test_drain: pop %0d stamp=%0d", i, out_stamp);
         tick();
      end
      checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL drain_empty: got valid=%0b level=%0d expected 0/0", out_valid, level); end
      checks++; if (out_stamp !== prev) begin errors++; $display("FAIL drain_hold: got %0d expected %0d", out_stamp, prev); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; thr = 6'd9;
      for (int i = 0; i < 5; i++) begin
         cnt_in = 6'd63; tick();
         cnt_in = 6'd0;  tick();
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      checks++; if (level !== 3'd3 || ovf !== 1'b1) begin errors++; $display("FAIL midrst_pre: got level=%0d ovf=%0b expected 3/1", level, ovf); end
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      checks++; if (out_valid !== 1'b0 || level !== 3'd0 || ovf !== 1'b0) begin
         errors++; $display("FAIL midrst_async: got valid=%0b level=%0d ovf=%0b expected 0/0/0", out_valid, level, ovf);
      end
      @(posedge clk);
      #1;
      thr = 6'd7; cnt_in = 6'd7; rst = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_first: got %0b expected 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL midrst_hold: got valid=%0b level=%0d expected 0/0", out_valid, level); end
      $display("test_reset_mid: valid=%0b level=%0d ovf=%0b", out_valid, level, ovf);
   endtask

   task automatic test_random();
      int nrec = 0;
      for (int n = 0; n < 600; n++) begin
         arm       = ($urandom_range(0, 7) != 0);
         out_ready = ($urandom_range(0, 3) == 0);
         ovf_clr   = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 9))
            0: cnt_in = 6'($urandom_range(0, 63));
            1: cnt_in = 6'd62;
            2: ;
            default: cnt_in = cnt_in + 6'd1;
         endcase
         if ($urandom_range(0, 7) == 0) thr = cnt_in + 6'($urandom_range(0, 3));
         tick();
         if (out_valid === 1'b1) nrec++;
         checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid n=%0d: got %0b expected %0b", n, out_valid, q.size() != 0); end
         checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level n=%0d: got %0d expected %0d", n, level, q.size()); end
         checks++; if (ovf !== ovf_m) begin errors++; $display("FAIL rnd_ovf n=%0d: got %0b expected %0b", n, ovf, ovf_m); end
         checks++; if (out_type !== last_head.t || out_cnt !== last_head.c || out_stamp !== last_head.s) begin
            errors++; $display("FAIL rnd_head n=%0d: got %0b/%0d/%0d expected %0b/%0d/%0d", n, out_type, out_cnt, out_stamp, last_head.t, last_head.c, last_head.s);
         end
      end
      $display("test_random: 600 cycles, valid cycles=%0d", nrec);
   endtask

   initial begin
      test_reset();
      test_match();
      test_wrap_both();
      test_overflow();
      test_full_pop();
      test_drain();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
